// File: rtl/maquina_pkg.sv
// Types shared by the vending-machine blocks: coin encoding, coin values
// and the change dispenser state set.
package maquina_pkg;

    typedef enum logic [1:0] {
        MONEDA_NONE = 2'b00,
        MONEDA_1    = 2'b01,
        MONEDA_2    = 2'b10,
        MONEDA_5    = 2'b11
    } moneda_t;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        ISSUE,
        DONE,
        FAULT
    } disp_state_t;

    function automatic logic [3:0] valor_moneda(input moneda_t m);
        logic [3:0] v;
        v = 4'd0;
        case (m)
            MONEDA_1: v = 4'd1;
            MONEDA_2: v = 4'd2;
            MONEDA_5: v = 4'd5;
            default:  v = 4'd0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/dispensador_cambio_coin_select.sv
// Greedy coin chooser: largest denomination that fits the remainder and
// still has stock, priority 5 > 2 > 1.
module coin_select
    import maquina_pkg::*;
(
    input  logic [3:0] remaining,
    input  logic [3:0] stock1,
    input  logic [3:0] stock2,
    input  logic [3:0] stock5,
    output logic       found,
    output logic [1:0] code
);

    always_comb begin
        found = 1'b0;
        code  = MONEDA_NONE;
        if (remaining >= 4'd5 && stock5 != 4'd0) begin
            found = 1'b1;
            code  = MONEDA_5;
        end else if (remaining >= 4'd2 && stock2 != 4'd0) begin
            found = 1'b1;
            code  = MONEDA_2;
        end else if (remaining >= 4'd1 && stock1 != 4'd0) begin
            found = 1'b1;
            code  = MONEDA_1;
        end
    end

endmodule

// File: rtl/dispensador_cambio.sv
// Change dispenser: pays an amount out coin by coin to the hopper,
// tracking per-denomination stock and flagging shortfalls.
//
// state  | meaning
// IDLE   | waiting for a change request; refill accepted here only
// SELECT | pick next coin, or fault if nothing fits
// ISSUE  | coin presented to hopper until ack or timeout
// DONE   | one-cycle completion pulse
// FAULT  | shortfall/timeout, remainder held until clear_fault
module dispensador_cambio
    import maquina_pkg::*;
#(
    parameter logic [3:0] STOCK1      = 4'd8,
    parameter logic [3:0] STOCK2      = 4'd4,
    parameter logic [3:0] STOCK5      = 4'd2,
    parameter logic [7:0] ACK_TIMEOUT = 8'd15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cambio_valid,
    input  logic [3:0] cambio,
    input  logic       coin_ack,
    input  logic       refill,
    input  logic       clear_fault,
    output logic       coin_valid,
    output logic [1:0] coin_out,
    output logic       busy,
    output logic       done,
    output logic       short_fault,
    output logic [3:0] pendiente,
    output logic [2:0] stock_empty
);

    disp_state_t state_q, state_d;
    moneda_t     coin_q, coin_d;
    logic [3:0]  rem_q, rem_d;
    logic [3:0]  pend_q, pend_d;
    logic [7:0]  tmo_q, tmo_d;
    logic [3:0]  stock1_q, stock1_d;
    logic [3:0]  stock2_q, stock2_d;
    logic [3:0]  stock5_q, stock5_d;
    logic        sel_found;
    logic [1:0]  sel_code;

    coin_select u_coin_select (
        .remaining (rem_q),
        .stock1    (stock1_q),
        .stock2    (stock2_q),
        .stock5    (stock5_q),
        .found     (sel_found),
        .code      (sel_code)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            coin_q   <= MONEDA_NONE;
            rem_q    <= 4'd0;
            pend_q   <= 4'd0;
            tmo_q    <= 8'd0;
            stock1_q <= STOCK1;
            stock2_q <= STOCK2;
            stock5_q <= STOCK5;
        end else begin
            state_q  <= state_d;
            coin_q   <= coin_d;
            rem_q    <= rem_d;
            pend_q   <= pend_d;
            tmo_q    <= tmo_d;
            stock1_q <= stock1_d;
            stock2_q <= stock2_d;
            stock5_q <= stock5_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        coin_d   = coin_q;
        rem_d    = rem_q;
        pend_d   = pend_q;
        tmo_d    = tmo_q;
        stock1_d = stock1_q;
        stock2_d = stock2_q;
        stock5_d = stock5_q;
        case (state_q)
            IDLE: begin
                if (cambio_valid) begin
                    if (cambio == 4'd0) begin
                        state_d = DONE;
                    end else begin
                        rem_d   = cambio;
                        state_d = SELECT;
                    end
                end else if (refill) begin
                    stock1_d = STOCK1;
                    stock2_d = STOCK2;
                    stock5_d = STOCK5;
                end
            end
            SELECT: begin
                if (sel_found) begin
                    coin_d  = moneda_t'(sel_code);
                    tmo_d   = 8'd0;
                    state_d = ISSUE;
                end else begin
                    pend_d  = rem_q;
                    state_d = FAULT;
                end
            end
            ISSUE: begin
                // ack takes priority over a timeout expiring in the same cycle
                if (coin_ack) begin
                    rem_d = rem_q - valor_moneda(coin_q);
                    case (coin_q)
                        MONEDA_1: stock1_d = stock1_q - 4'd1;
                        MONEDA_2: stock2_d = stock2_q - 4'd1;
                        MONEDA_5: stock5_d = stock5_q - 4'd1;
                        default:  ;
                    endcase
                    coin_d  = MONEDA_NONE;
                    state_d = (rem_d == 4'd0) ? DONE : SELECT;
                end else if (tmo_q == ACK_TIMEOUT - 8'd1) begin
                    pend_d  = rem_q;
                    coin_d  = MONEDA_NONE;
                    state_d = FAULT;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            FAULT: begin
                if (clear_fault) begin
                    pend_d  = 4'd0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign coin_valid  = (state_q == ISSUE);
    assign coin_out    = coin_valid ? coin_q : MONEDA_NONE;
    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign short_fault = (state_q == FAULT);
    assign pendiente   = pend_q;
    assign stock_empty = {stock5_q == 4'd0, stock2_q == 4'd0, stock1_q == 4'd0};

endmodule

// File: tb/tb_dispensador_cambio.sv
// Directed bench for the change dispenser: three instances with different
// stock parameters share stimulus; per-instance hopper models ack coins.
module tb_dispensador_cambio;

    logic       clk = 1'b0;
    logic       reset;
    logic       cambio_valid;
    logic [3:0] cambio;
    logic       refill;
    logic       clear_fault;
    logic [2:0] ack = 3'b000;
    logic [2:0] hop_en;
    logic [2:0] cv, busy, done, sf;
    logic [1:0] co [3];
    logic [3:0] pend [3];
    logic [2:0] se [3];

    logic [1:0] lg [3][32];
    int         nl [3] = '{0, 0, 0};
    int         n_tests = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    dispensador_cambio u0 (
        .clk(clk), .reset(reset), .cambio_valid(cambio_valid), .cambio(cambio),
        .coin_ack(ack[0]), .refill(refill), .clear_fault(clear_fault),
        .coin_valid(cv[0]), .coin_out(co[0]), .busy(busy[0]), .done(done[0]),
        .short_fault(sf[0]), .pendiente(pend[0]), .stock_empty(se[0])
    );

    dispensador_cambio #(.STOCK5(4'd0)) u1 (
        .clk(clk), .reset(reset), .cambio_valid(cambio_valid), .cambio(cambio),
        .coin_ack(ack[1]), .refill(refill), .clear_fault(clear_fault),
        .coin_valid(cv[1]), .coin_out(co[1]), .busy(busy[1]), .done(done[1]),
        .short_fault(sf[1]), .pendiente(pend[1]), .stock_empty(se[1])
    );

    dispensador_cambio #(.STOCK1(4'd1), .STOCK2(4'd0)) u2 (
        .clk(clk), .reset(reset), .cambio_valid(cambio_valid), .cambio(cambio),
        .coin_ack(ack[2]), .refill(refill), .clear_fault(clear_fault),
        .coin_valid(cv[2]), .coin_out(co[2]), .busy(busy[2]), .done(done[2]),
        .short_fault(sf[2]), .pendiente(pend[2]), .stock_empty(se[2])
    );

    // Hopper: logs a newly presented coin and acks it one cycle later.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (hop_en[i] && cv[i] && !ack[i]) begin
                if (nl[i] < 32) lg[i][nl[i]] = co[i];
                nl[i]++;
            end
            ack[i] = hop_en[i] && cv[i] && !ack[i];
        end
    end

    function automatic logic [31:0] seq_of(input int i, input int b);
        logic [31:0] s;
        s = '0;
        for (int k = b; k < nl[i] && k < 32; k++) s = {s[29:0], lg[i][k]};
        return s;
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic send(input logic [3:0] amt);
        cambio       = amt;
        cambio_valid = 1'b1;
        tick();
        cambio_valid = 1'b0;
    endtask

    task automatic wait_end(input int i, output logic sd, output logic sfo);
        sd  = 1'b0;
        sfo = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (done[i]) begin sd = 1'b1; break; end
            if (sf[i]) begin sfo = 1'b1; break; end
            tick();
        end
        if (!sd && !sfo) begin
            n_tests++; n_fail++;
            $display("FAIL wait_end dut%0d: neither done nor fault within 200 cycles", i);
        end
    endtask

    task automatic wait_coins(input int i, input int b, input int n);
        int k;
        for (k = 0; k < 50 && (nl[i] - b) < n; k++) tick();
        if ((nl[i] - b) < n) begin
            n_tests++; n_fail++;
            $display("FAIL wait_coins dut%0d: got %0d coins, required %0d", i, nl[i] - b, n);
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if ({cv[0], co[0], busy[0], done[0], sf[0], pend[0]} !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h required 000", {cv[0], co[0], busy[0], done[0], sf[0], pend[0]});
        end
        n_tests++;
        if ({se[0], se[1], se[2]} !== {3'b000, 3'b100, 3'b010}) begin
            n_fail++;
            $display("FAIL reset_stock_empty: got %b required 000100010", {se[0], se[1], se[2]});
        end
    endtask

    task automatic test_pay8();
        logic sd, sfo;
        int   b;
        do_reset();
        b = nl[0];
        send(4'd8);
        n_tests++;
        if ({busy[0], cv[0]} !== 2'b10) begin
            n_fail++;
            $display("FAIL pay8_select: busy,valid got %b required 10", {busy[0], cv[0]});
        end
        tick();
        n_tests++;
        if ({cv[0], co[0]} !== 3'b111) begin
            n_fail++;
            $display("FAIL pay8_latency: valid,coin got %b required 111", {cv[0], co[0]});
        end
        wait_end(0, sd, sfo);
        n_tests++;
        if ({sd, sfo} !== 2'b10 || nl[0] - b != 3 || seq_of(0, b) !== 32'h39) begin
            n_fail++;
            $display("FAIL pay8_coins: done/fault %b count %0d seq %h required 10 3 39", {sd, sfo}, nl[0] - b, seq_of(0, b));
        end
        n_tests++;
        if ({u0.stock5_q, u0.stock2_q, u0.stock1_q} !== 12'h137) begin
            n_fail++;
            $display("FAIL pay8_stock: got %h required 137", {u0.stock5_q, u0.stock2_q, u0.stock1_q});
        end
        tick();
        n_tests++;
        if ({done[0], busy[0]} !== 2'b00) begin
            n_fail++;
            $display("FAIL pay8_done_pulse: done,busy got %b required 00", {done[0], busy[0]});
        end
    endtask

    task automatic test_pay4();
        logic sd, sfo;
        int   b;
        do_reset();
        b = nl[0];
        send(4'd4);
        wait_end(0, sd, sfo);
        n_tests++;
        if ({sd, sfo} !== 2'b10 || nl[0] - b != 2 || seq_of(0, b) !== 32'hA) begin
            n_fail++;
            $display("FAIL pay4_coins: done/fault %b count %0d seq %h required 10 2 a", {sd, sfo}, nl[0] - b, seq_of(0, b));
        end
        n_tests++;
        if ({u0.stock5_q, u0.stock2_q} !== 8'h22) begin
            n_fail++;
            $display("FAIL pay4_stock: s5,s2 got %h required 22", {u0.stock5_q, u0.stock2_q});
        end
    endtask

    task automatic test_no_five();
        logic sd, sfo;
        int   b;
        do_reset();
        b = nl[1];
        send(4'd7);
        wait_end(1, sd, sfo);
        n_tests++;
        if ({sd, sfo} !== 2'b10 || nl[1] - b != 4 || seq_of(1, b) !== 32'hA9) begin
            n_fail++;
            $display("FAIL no5_first: done/fault %b count %0d seq %h required 10 4 a9", {sd, sfo}, nl[1] - b, seq_of(1, b));
        end
        tick(); tick(); tick();
        b = nl[1];
        send(4'd7);
        wait_end(1, sd, sfo);
        n_tests++;
        if ({sd, sfo} !== 2'b10 || nl[1] - b != 6 || seq_of(1, b) !== 32'h955) begin
            n_fail++;
            $display("FAIL no5_second: done/fault %b count %0d seq %h required 10 6 955", {sd, sfo}, nl[1] - b, seq_of(1, b));
        end
        n_tests++;
        if (se[1] !== 3'b110) begin
            n_fail++;
            $display("FAIL no5_stock_empty: got %b required 110", se[1]);
        end
    endtask

    task automatic test_shortfall();
        logic sd, sfo;
        int   b;
        do_reset();
        b = nl[2];
        send(4'd3);
        wait_end(2, sd, sfo);
        n_tests++;
        if ({sd, sfo} !== 2'b01 || nl[2] - b != 1 || seq_of(2, b) !== 32'h1) begin
            n_fail++;
            $display("FAIL short_coins: done/fault %b count %0d seq %h required 01 1 1", {sd, sfo}, nl[2] - b, seq_of(2, b));
        end
        tick(); tick();
        n_tests++;
        if ({sf[2], pend[2], done[2], se[2]} !== 9'b1_0010_0_011) begin
            n_fail++;
            $display("FAIL short_held: fault,pend,done,empty got %b required 100100011", {sf[2], pend[2], done[2], se[2]});
        end
        clear_fault = 1'b1;
        tick();
        clear_fault = 1'b0;
        n_tests++;
        if ({busy[2], sf[2], pend[2]} !== 6'd0) begin
            n_fail++;
            $display("FAIL short_clear: busy,fault,pend got %b required 000000", {busy[2], sf[2], pend[2]});
        end
    endtask

    task automatic test_timeout();
        int cnt;
        do_reset();
        hop_en[0] = 1'b0;
        send(4'd5);
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (cv[0]) cnt++;
            else if (cnt > 0) break;
        end
        n_tests++;
        if (cnt != 15) begin
            n_fail++;
            $display("FAIL timeout_cycles: valid high %0d cycles, required 15", cnt);
        end
        n_tests++;
        if ({sf[0], pend[0], co[0], u0.stock5_q} !== 11'b1_0101_00_0010) begin
            n_fail++;
            $display("FAIL timeout_fault: fault,pend,coin,s5 got %b required 10101000010", {sf[0], pend[0], co[0], u0.stock5_q});
        end
        clear_fault = 1'b1;
        tick();
        clear_fault = 1'b0;
        hop_en[0] = 1'b1;
    endtask

    task automatic test_reset_mid();
        logic sd, sfo;
        int   b;
        do_reset();
        b = nl[0];
        send(4'd8);
        wait_coins(0, b, 2);
        reset = 1'b0;
        tick();
        n_tests++;
        if ({cv[0], co[0], busy[0], done[0], sf[0], pend[0]} !== 10'd0 || u0.stock5_q !== 4'd2) begin
            n_fail++;
            $display("FAIL reset_mid: outputs %h s5 %0d required 000 2", {cv[0], co[0], busy[0], done[0], sf[0], pend[0]}, u0.stock5_q);
        end
        reset = 1'b1;
        tick();
        b = nl[0];
        send(4'd8);
        wait_coins(0, b, 2);
        refill = 1'b1;
        tick();
        refill = 1'b0;
        wait_end(0, sd, sfo);
        n_tests++;
        if (sd !== 1'b1 || {u0.stock5_q, u0.stock2_q, u0.stock1_q} !== 12'h137) begin
            n_fail++;
            $display("FAIL refill_busy: done %b stock %h required 1 137", sd, {u0.stock5_q, u0.stock2_q, u0.stock1_q});
        end
        tick();
        refill = 1'b1;
        tick();
        refill = 1'b0;
        n_tests++;
        if ({u0.stock5_q, u0.stock2_q, u0.stock1_q} !== 12'h248) begin
            n_fail++;
            $display("FAIL refill_idle: stock %h required 248", {u0.stock5_q, u0.stock2_q, u0.stock1_q});
        end
        b = nl[0];
        send(4'd0);
        n_tests++;
        if ({done[0], cv[0]} !== 2'b10) begin
            n_fail++;
            $display("FAIL zero_done: done,valid got %b required 10", {done[0], cv[0]});
        end
        tick();
        n_tests++;
        if ({done[0], busy[0]} !== 2'b00 || nl[0] != b) begin
            n_fail++;
            $display("FAIL zero_after: done,busy %b coins %0d required 00 0", {done[0], busy[0]}, nl[0] - b);
        end
    endtask

    initial begin
        reset        = 1'b0;
        cambio_valid = 1'b0;
        cambio       = 4'd0;
        refill       = 1'b0;
        clear_fault  = 1'b0;
        hop_en       = 3'b111;
        test_reset();
        test_pay8();
        test_pay4();
        test_no_five();
        test_shortfall();
        test_timeout();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
